sap_control_sequencer: RTL

- Initiator side of the active-low bus load/output-enable protocol used by the 8-bit bus registers.
- Steps through fetch/execute T-states.
- Decodes the opcode held in the instruction register.
- Drives every register's n_load and n_oe strobe, so that exactly one source drives the bus and the intended destinations latch it on the next clk edge.
- Supports free-running mode and manual single-step mode.

---
 rtl/sap_pkg.sv | 46 ++++
 rtl/sap_control_sequencer_if.sv | 55 +++++
 rtl/step_edge_sync.sv | 29 ++
 rtl/sap_control_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer.
// Opcodes, T-state encoding and the internal active-high control bundle.
package sap_pkg;

  localparam int T_STATES_DEFAULT    = 5;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic oe_pc;
    logic oe_ram;
    logic oe_ir;
    logic oe_a;
    logic oe_alu;
    logic ld_mar;
    logic ld_ir;
    logic ld_a;
    logic ld_b;
    logic ld_out;
    logic ld_pc;
    logic ld_flags;
    logic we_ram;
    logic pc_inc;
    logic alu_sub;
  } ctrl_t;

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Bus-control bundle between the sequencer and the datapath registers.
// Strobes are active-low, as the bus registers expect.
interface sap_control_sequencer_if;

  logic [7:0] instr;
  logic       flag_c;
  logic       flag_z;
  logic       manual;
  logic       step;

  logic       n_oe_pc;
  logic       n_oe_ram;
  logic       n_oe_ir;
  logic       n_oe_a;
  logic       n_oe_alu;
  logic       n_load_mar;
  logic       n_load_ir;
  logic       n_load_a;
  logic       n_load_b;
  logic       n_load_out;
  logic       n_load_pc;
  logic       n_load_flags;
  logic       n_we_ram;
  logic       pc_inc;
  logic       alu_sub;
  logic       halt;
  logic [2:0] tstate;

  modport master (
    input  instr, flag_c, flag_z,
    input  manual, step,
    output n_oe_pc, n_oe_ram, n_oe_ir,
    output n_oe_a, n_oe_alu,
    output n_load_mar, n_load_ir,
    output n_load_a, n_load_b,
    output n_load_out, n_load_pc,
    output n_load_flags, n_we_ram,
    output pc_inc, alu_sub,
    output halt, tstate
  );

  modport slave (
    output instr, flag_c, flag_z,
    output manual, step,
    input  n_oe_pc, n_oe_ram, n_oe_ir,
    input  n_oe_a, n_oe_alu,
    input  n_load_mar, n_load_ir,
    input  n_load_a, n_load_b,
    input  n_load_out, n_load_pc,
    input  n_load_flags, n_we_ram,
    input  pc_inc, alu_sub,
    input  halt, tstate
  );

endinterface

// File: rtl/step_edge_sync.sv
// Synchroniser for the asynchronous step button plus rising-edge
// detector; emits a single-cycle pulse per synchronised press.
module step_edge_sync
  import sap_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_step,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_step};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: T-state counter, halt latch and microcode
// decode driving the active-low bus strobes.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int T_STATES    = T_STATES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input logic                     clk,
  input logic                     rst,
  sap_control_sequencer_if.master bus
);

  localparam logic [2:0] LAST = 3'(T_STATES - 1);

  tstate_e    r_tstate;
  logic       r_halt;
  logic       w_pulse;
  logic       w_adv;
  logic       w_oe_en;
  logic       w_ld_en;
  logic [3:0] w_op;
  logic       w_unused_operand;
  ctrl_t      w_c;

  step_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_step (
    .clk    (clk),
    .rst    (rst),
    .i_step (bus.step),
    .o_pulse(w_pulse)
  );

  assign w_op             = bus.instr[7:4];
  assign w_unused_operand = ^bus.instr[3:0];

  assign w_adv   = ~r_halt & (bus.manual ? w_pulse : 1'b1);
  assign w_oe_en = ~rst;
  assign w_ld_en = w_adv & ~rst;

  // HLT freezes the counter on T2 instead of advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tstate <= T0;
      r_halt   <= 1'b0;
    end else if (w_adv) begin
      if (r_tstate == T2 && w_op == OP_HLT) begin
        r_halt <= 1'b1;
      end else if (r_tstate == tstate_e'(LAST)) begin
        r_tstate <= T0;
      end else begin
        r_tstate <= tstate_e'(r_tstate + 3'd1);
      end
    end
  end

  always_comb begin
    w_c = '0;
    unique case (r_tstate)
      T0: begin
        w_c.oe_pc  = 1'b1;
        w_c.ld_mar = 1'b1;
      end
      T1: begin
        w_c.oe_ram = 1'b1;
        w_c.ld_ir  = 1'b1;
        w_c.pc_inc = 1'b1;
      end
      T2: begin
        unique case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w_c.oe_ir  = 1'b1;
            w_c.ld_mar = 1'b1;
          end
          OP_LDI: begin
            w_c.oe_ir = 1'b1;
            w_c.ld_a  = 1'b1;
          end
          OP_JMP: begin
            w_c.oe_ir = 1'b1;
            w_c.ld_pc = 1'b1;
          end
          OP_JC: begin
            w_c.oe_ir = bus.flag_c;
            w_c.ld_pc = bus.flag_c;
          end
          OP_JZ: begin
            w_c.oe_ir = bus.flag_z;
            w_c.ld_pc = bus.flag_z;
          end
          OP_OUT: begin
            w_c.oe_a   = 1'b1;
            w_c.ld_out = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        unique case (w_op)
          OP_LDA: begin
            w_c.oe_ram = 1'b1;
            w_c.ld_a   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_c.oe_ram = 1'b1;
            w_c.ld_b   = 1'b1;
          end
          OP_STA: begin
            w_c.oe_a   = 1'b1;
            w_c.we_ram = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (w_op == OP_ADD || w_op == OP_SUB) begin
          w_c.oe_alu   = 1'b1;
          w_c.ld_a     = 1'b1;
          w_c.ld_flags = 1'b1;
          w_c.alu_sub  = (w_op == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // Bus enables stay up while waiting; side-effecting strobes need adv.
  assign bus.n_oe_pc      = ~(w_c.oe_pc    & w_oe_en);
  assign bus.n_oe_ram     = ~(w_c.oe_ram   & w_oe_en);
  assign bus.n_oe_ir      = ~(w_c.oe_ir    & w_oe_en);
  assign bus.n_oe_a       = ~(w_c.oe_a     & w_oe_en);
  assign bus.n_oe_alu     = ~(w_c.oe_alu   & w_oe_en);
  assign bus.n_load_mar   = ~(w_c.ld_mar   & w_ld_en);
  assign bus.n_load_ir    = ~(w_c.ld_ir    & w_ld_en);
  assign bus.n_load_a     = ~(w_c.ld_a     & w_ld_en);
  assign bus.n_load_b     = ~(w_c.ld_b     & w_ld_en);
  assign bus.n_load_out   = ~(w_c.ld_out   & w_ld_en);
  assign bus.n_load_pc    = ~(w_c.ld_pc    & w_ld_en);
  assign bus.n_load_flags = ~(w_c.ld_flags & w_ld_en);
  assign bus.n_we_ram     = ~(w_c.we_ram   & w_ld_en);
  assign bus.pc_inc       =   w_c.pc_inc   & w_ld_en;
  assign bus.alu_sub      =   w_c.alu_sub  & w_oe_en;
  assign bus.halt         = r_halt;
  assign bus.tstate       = r_tstate;

endmodule
